fb_access_sched: RTL

//  Sequences the shared camera frame buffer between ov7670 capture (write port) and the two

---
 rtl/fb_access_sched_pkg.sv | 29 ++
 rtl/fb_access_sched_if.sv | 40 ++++
 rtl/fb_access_sched_rd_arb.sv | 41 ++++
 rtl/fb_access_sched.sv | 108 ++++++++++
 4 files changed

// File: rtl/fb_access_sched_pkg.sv
// Shared types and constants for the frame-buffer access scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fb_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    CAPTURE = 3'd2,
    DISPLAY = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam int C_IMG_PXLS_DEF = 4800;

  // Bits needed to hold values 0..val-1; used to size counters from parameters.
  function automatic int clog2(input int val);
    int res;
    int v;
    res = 0;
    v   = val - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fb_access_sched_if.sv
// Bundle of capture, OLED control and frame-buffer read-port signals around the scheduler.
// Latency: n/a (wiring only).
// Backpressure: OLED holds oled_req/oled_addr until oled_gnt; VGA is never stalled.
interface fb_access_sched_if #(
  parameter int C_NB_ADDR = 13,
  parameter int C_NB_PXL  = 16
);

  logic                 cap_vsync;
  logic                 cap_we_in;
  logic                 freeze;
  logic                 fb_wea;
  logic                 oled_en;
  logic                 oled_done;
  logic                 vga_req;
  logic [C_NB_ADDR-1:0] vga_addr;
  logic                 oled_req;
  logic [C_NB_ADDR-1:0] oled_addr;
  logic [C_NB_ADDR-1:0] fb_addrb;
  logic [C_NB_PXL-1:0]  fb_doutb;
  logic                 vga_valid;
  logic                 oled_gnt;
  logic                 oled_valid;
  logic                 frame_err;

  // Scheduler side.
  modport slave (
    input  cap_vsync, cap_we_in, freeze, oled_done,
    input  vga_req, vga_addr, oled_req, oled_addr, fb_doutb,
    output fb_wea, oled_en, fb_addrb, vga_valid, oled_gnt, oled_valid, frame_err
  );

  // Surrounding system side (camera, readers, frame buffer).
  modport master (
    output cap_vsync, cap_we_in, freeze, oled_done,
    output vga_req, vga_addr, oled_req, oled_addr, fb_doutb,
    input  fb_wea, oled_en, fb_addrb, vga_valid, oled_gnt, oled_valid, frame_err
  );

endinterface

// File: rtl/fb_access_sched_rd_arb.sv
// Fixed-priority (VGA over OLED) mux onto the shared frame-buffer read port.
// Latency: address/grant combinational; valid flags 1 cycle later to line up with RAM data.
// Backpressure: OLED is refused while VGA requests and must hold its request.
module fb_rd_arb #(
  parameter int C_NB_ADDR = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vga_req,
  input  logic [C_NB_ADDR-1:0] vga_addr,
  input  logic                 oled_req,
  input  logic [C_NB_ADDR-1:0] oled_addr,
  output logic [C_NB_ADDR-1:0] fb_addrb,
  output logic                 oled_gnt,
  output logic                 vga_valid,
  output logic                 oled_valid
);

  // VGA owns the port whenever it asks; OLED gets the leftover cycles.
  always_comb begin
    fb_addrb = oled_addr;
    oled_gnt = 1'b0;
    if (vga_req) begin
      fb_addrb = vga_addr;
    end else begin
      oled_gnt = oled_req;
    end
  end

  // Tag the RAM output one cycle after the address was presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_valid  <= 1'b0;
      oled_valid <= 1'b0;
    end else begin
      vga_valid  <= vga_req;
      oled_valid <= oled_gnt;
    end
  end

endmodule

// File: rtl/fb_access_sched.sv
// Gates camera writes into whole-frame bursts, freezes the buffer for OLED scan-out, arbitrates reads.
// Latency: fb_wea/fb_addrb/oled_gnt combinational; oled_en, valids and frame_err registered (1 cycle).
// Backpressure: capture is never stalled, only dropped outside CAPTURE; OLED reads wait behind VGA.
module fb_access_sched
  import fb_sched_pkg::*;
#(
  parameter int C_NB_ADDR    = 13,
  parameter int C_NB_PXL     = 16,
  parameter int C_IMG_PXLS   = C_IMG_PXLS_DEF,
  parameter int C_CAP_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fb_access_sched_if.slave  bus
);

  localparam int C_NB_PIX = clog2(C_IMG_PXLS + 1);
  localparam int C_NB_FRM = clog2(C_CAP_FRAMES + 1);
  localparam logic [C_NB_PIX-1:0] PIX_FULL = C_NB_PIX'(C_IMG_PXLS);
  localparam logic [C_NB_FRM-1:0] FRM_LAST = C_NB_FRM'(C_CAP_FRAMES);

  state_t              state;
  logic                cap_vsync_q;
  logic                vs_rise;
  logic [C_NB_PIX-1:0] pix_cnt;
  logic [C_NB_FRM-1:0] frm_cnt;
  logic [C_NB_FRM-1:0] frm_cnt_nxt;
  logic                oled_en_r;
  logic                frame_err_r;

  assign vs_rise     = bus.cap_vsync & ~cap_vsync_q;
  assign frm_cnt_nxt = frm_cnt + 1'b1;

  // Writes pass straight through only while capturing; freeze cuts them in the same cycle.
  assign bus.fb_wea    = (state == CAPTURE) & bus.cap_we_in & ~bus.freeze;
  assign bus.oled_en   = oled_en_r;
  assign bus.frame_err = frame_err_r;

  // Capture/freeze sequencing, frame counting and vsync edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap_vsync_q <= 1'b0;
      pix_cnt     <= '0;
      frm_cnt     <= '0;
      oled_en_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      cap_vsync_q <= bus.cap_vsync;
      oled_en_r   <= (state == DISPLAY);
      case (state)
        IDLE: state <= SYNC;
        SYNC: begin
          if (vs_rise && !bus.freeze) begin
            state   <= CAPTURE;
            pix_cnt <= '0;
            frm_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (bus.freeze) begin
            // Partial frame is abandoned; frame count is left as is.
            state <= HOLD;
          end else if (vs_rise) begin
            pix_cnt <= '0;
            if (pix_cnt == PIX_FULL) begin
              frm_cnt <= frm_cnt_nxt;
              if (frm_cnt_nxt == FRM_LAST) begin
                state <= DISPLAY;
              end
            end else begin
              frame_err_r <= 1'b1;
            end
          end else if (bus.cap_we_in && (pix_cnt != PIX_FULL)) begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
        DISPLAY: begin
          if (bus.oled_done) begin
            state <= SYNC;
          end
        end
        HOLD: begin
          if (!bus.freeze) begin
            state <= SYNC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fb_rd_arb #(
    .C_NB_ADDR (C_NB_ADDR)
  ) u_rd_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_req    (bus.vga_req),
    .vga_addr   (bus.vga_addr),
    .oled_req   (bus.oled_req),
    .oled_addr  (bus.oled_addr),
    .fb_addrb   (bus.fb_addrb),
    .oled_gnt   (bus.oled_gnt),
    .vga_valid  (bus.vga_valid),
    .oled_valid (bus.oled_valid)
  );

endmodule
